priority_encoder8x3: RTL and testbench

//   Sequential 8-to-3 request encoder, the inverse of the 3x8 line decoder.
//   - Latches one-hot/multi-hot request lines into a pending register.
//   - Issues one 3-bit index per cycle through a valid/ready output stage.
//   - Sits between per-line event sources and any consumer that re-decodes the index.

---
 rtl/priority_encoder8x3.sv | 111 +++++++++++
 tb/tb_priority_encoder8x3.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/priority_encoder8x3.sv
// ----------------------------------------------------------------------------
// priority_encoder8x3
//   Sequential 8-to-3 request encoder. Request lines are latched into an
//   8-bit pending register. One pending index is issued per cycle through a
//   registered valid/ready output stage.
//
//   Handshake: out/out_valid form a valid/ready source. A transfer happens at
//   a rising edge where out_valid && out_ready. While out_valid && !out_ready,
//   out and out_valid are held stable. out_valid never drops without a
//   transfer, except on rst.
//
//   Configuration macro: ROUND_ROBIN_EN
//     undefined : fixed priority, highest pending index wins (bit 7 highest)
//     defined   : round robin, search starts one above the last issued index
//
// Ports
//   clk        in   1  clock, all state on rising edge
//   rst        in   1  synchronous active-high reset
//   in         in   8  request lines, in[i]=1 posts request i
//   out        out  3  index being offered
//   out_valid  out  1  out holds a valid index
//   out_ready  in   1  consumer accepts out this cycle
//   busy       out  1  requests pending or an index in flight
//   merged     out  1  sticky: a request hit an already-pending line
// ----------------------------------------------------------------------------
module priority_encoder8x3 (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in,
    output logic [2:0] out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       merged
);

    logic [7:0] pending;
    logic [2:0] sel;
    logic       load;
    logic [7:0] clear_mask;

`ifdef ROUND_ROBIN_EN
    logic [2:0] rr_ptr;
    logic [2:0] idx;
    logic       found;

    // Walk upward from rr_ptr+1, wrapping naturally in 3-bit arithmetic;
    // the first set pending bit wins.
    always_comb begin
        sel   = 3'd0;
        idx   = 3'd0;
        found = 1'b0;
        for (int j = 0; j < 8; j++) begin
            idx = rr_ptr + 3'(j) + 3'd1;
            if (!found && pending[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end
`else
    // Later iterations overwrite earlier ones, so the highest set bit wins.
    always_comb begin
        sel = 3'd0;
        for (int j = 0; j < 8; j++) begin
            if (pending[j]) begin
                sel = 3'(j);
            end
        end
    end
`endif

    // The stage takes a new index when it is empty or being emptied,
    // and there is something to issue. Selection sees pre-edge pending only.
    assign load       = (!out_valid || out_ready) && (pending != 8'd0);
    assign clear_mask = 8'd1 << sel;
    assign busy       = (|pending) | out_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            pending   <= 8'd0;
            out       <= 3'd0;
            out_valid <= 1'b0;
            merged    <= 1'b0;
`ifdef ROUND_ROBIN_EN
            rr_ptr    <= 3'd7;
`endif
        end else begin
            if (|(in & pending)) begin
                merged <= 1'b1;
            end
            if (load) begin
                out       <= sel;
                out_valid <= 1'b1;
                // OR-ing in after the clear lets a same-cycle request on the
                // issued line keep it pending.
                pending   <= (pending & ~clear_mask) | in;
`ifdef ROUND_ROBIN_EN
                rr_ptr    <= sel;
`endif
            end else begin
                pending <= pending | in;
                // Only reachable with pending==0 when ready is high: drain.
                if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_priority_encoder8x3.sv
module tb_priority_encoder8x3;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [2:0] out;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       merged;

  int checks;
  int errors;

  logic [2:0] exp_q[$];

  // reference model state
  bit       m_pend[8];
  bit       m_valid;
  int       m_out;
  bit       m_merged;
  int       m_ptr;

  priority_encoder8x3 dut (
    .clk       (clk),
    .rst       (rst),
    .in        (req),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .merged    (merged)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model_pick();
    int k;
    k = -1;
`ifdef ROUND_ROBIN_EN
    for (int d = 1; d <= 8; d++) begin
      if (k < 0 && m_pend[(m_ptr + d) % 8]) k = (m_ptr + d) % 8;
    end
`else
    for (int i = 7; i >= 0; i--) begin
      if (k < 0 && m_pend[i]) k = i;
    end
`endif
    return k;
  endfunction

  function automatic bit model_any_pending();
    bit a;
    a = 0;
    for (int i = 0; i < 8; i++) a = a | m_pend[i];
    return a;
  endfunction

  function automatic bit model_busy();
    return model_any_pending() || m_valid;
  endfunction

  // Advance the model by one rising edge using pre-edge state and inputs.
  task automatic model_update(input logic [7:0] i_in, input logic i_rdy, input logic i_rst);
    int k;
    if (i_rst) begin
      for (int i = 0; i < 8; i++) m_pend[i] = 0;
      m_valid = 0; m_out = 0; m_merged = 0; m_ptr = 7;
    end else begin
      for (int i = 0; i < 8; i++) if (i_in[i] && m_pend[i]) m_merged = 1;
      if ((!m_valid || i_rdy) && model_any_pending()) begin
        k = model_pick();
        m_out = k; m_valid = 1; m_ptr = k;
        m_pend[k] = 0;
      end else if (m_valid && i_rdy) begin
        m_valid = 0;
      end
      for (int i = 0; i < 8; i++) if (i_in[i]) m_pend[i] = 1;
    end
  endtask

  // driver: one cycle of stimulus, outputs sampled 1ns after the edge
  task automatic step(input logic [7:0] i_in, input logic i_rdy, input logic i_rst);
    @(negedge clk);
    req = i_in; out_ready = i_rdy; rst = i_rst;
    @(posedge clk);
    model_update(i_in, i_rdy, i_rst);
    #1;
  endtask

  task automatic test_reset();
    step(8'hFF, 1'b0, 1'b1);
    step(8'hFF, 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (merged !== 1'b0) begin errors++; $display("FAIL reset_merged got %0b want 0", merged); end
    checks++; if (out !== 3'd0) begin errors++; $display("FAIL reset_out got %0d want 0", out); end
    step(8'h00, 1'b1, 1'b0);
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL reset_idle busy=%0b valid=%0b want 0 0", busy, out_valid); end
  endtask

  task automatic test_fixed_order();
    step(8'h00, 1'b1, 1'b1);
    step(8'b0010_0100, 1'b1, 1'b0);
    checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL order_latch busy=%0b valid=%0b want 1 0", busy, out_valid); end
    exp_q.delete();
`ifdef ROUND_ROBIN_EN
    exp_q.push_back(3'd2); exp_q.push_back(3'd5);
`else
    exp_q.push_back(3'd5); exp_q.push_back(3'd2);
`endif
    while (exp_q.size() > 0) begin
      logic [2:0] e;
      e = exp_q.pop_front();
      step(8'h00, 1'b1, 1'b0);
      checks++; if (out_valid !== 1'b1 || out !== e) begin errors++; $display("FAIL order_issue valid=%0b out=%0d want 1 %0d", out_valid, out, e); end
    end
    step(8'h00, 1'b1, 1'b0);
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL order_idle valid=%0b busy=%0b want 0 0", out_valid, busy); end
  endtask

  task automatic test_backpressure();
    logic [2:0] first, second;
`ifdef ROUND_ROBIN_EN
    first = 3'd2; second = 3'd5;
`else
    first = 3'd5; second = 3'd2;
`endif
    step(8'h00, 1'b1, 1'b1);
    step(8'b0010_0100, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      step(8'h00, 1'b0, 1'b0);
      checks++; if (out_valid !== 1'b1 || out !== first || busy !== 1'b1) begin errors++; $display("FAIL bp_hold valid=%0b out=%0d busy=%0b want 1 %0d 1", out_valid, out, busy, first); end
    end
    step(8'h00, 1'b1, 1'b0);
    checks++; if (out_valid !== 1'b1 || out !== second) begin errors++; $display("FAIL bp_next valid=%0b out=%0d want 1 %0d", out_valid, out, second); end
    step(8'h00, 1'b1, 1'b0);
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_idle valid=%0b busy=%0b want 0 0", out_valid, busy); end
  endtask

  task automatic test_merge();
    step(8'h00, 1'b1, 1'b1);
    step(8'h01, 1'b0, 1'b0);
    checks++; if (merged !== 1'b0) begin errors++; $display("FAIL merge_early got %0b want 0", merged); end
    step(8'h01, 1'b0, 1'b0);
    checks++; if (merged !== 1'b1) begin errors++; $display("FAIL merge_set got %0b want 1", merged); end
    checks++; if (out_valid !== 1'b1 || out !== 3'd0) begin errors++; $display("FAIL merge_first valid=%0b out=%0d want 1 0", out_valid, out); end
    step(8'h00, 1'b1, 1'b0);
    checks++; if (out_valid !== 1'b1 || out !== 3'd0) begin errors++; $display("FAIL merge_second valid=%0b out=%0d want 1 0", out_valid, out); end
    step(8'h00, 1'b1, 1'b0);
    checks++; if (out_valid !== 1'b0 || merged !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL merge_sticky valid=%0b merged=%0b busy=%0b want 0 1 0", out_valid, merged, busy); end
    step(8'h00, 1'b1, 1'b1);
    checks++; if (merged !== 1'b0) begin errors++; $display("FAIL merge_clear got %0b want 0", merged); end
  endtask

  task automatic test_arbitration();
    step(8'h00, 1'b1, 1'b1);
    step(8'hFF, 1'b1, 1'b0);
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
`ifdef ROUND_ROBIN_EN
      exp_q.push_back(3'(i));
`else
      exp_q.push_back(3'(7 - i));
`endif
    end
    while (exp_q.size() > 0) begin
      logic [2:0] e;
      e = exp_q.pop_front();
      step(8'h00, 1'b1, 1'b0);
      checks++; if (out_valid !== 1'b1 || out !== e) begin errors++; $display("FAIL arb_issue valid=%0b out=%0d want 1 %0d", out_valid, out, e); end
    end
    step(8'h00, 1'b1, 1'b0);
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL arb_idle valid=%0b busy=%0b want 0 0", out_valid, busy); end
  endtask

  task automatic test_reset_midstream();
    step(8'h00, 1'b1, 1'b1);
    step(8'hF0, 1'b1, 1'b0);
    step(8'h00, 1'b1, 1'b0);
    step(8'h00, 1'b1, 1'b0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_issuing valid=%0b want 1", out_valid); end
    step(8'h00, 1'b1, 1'b1);
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_rst valid=%0b busy=%0b want 0 0", out_valid, busy); end
    for (int c = 0; c < 4; c++) begin
      step(8'h00, 1'b1, 1'b0);
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_after valid=%0b busy=%0b want 0 0", out_valid, busy); end
    end
  endtask

  task automatic test_random();
    logic [7:0] r_in;
    logic       r_rdy, r_rst;
    for (int c = 0; c < 400; c++) begin
      r_in  = 8'($urandom) & 8'($urandom) & 8'($urandom);
      r_rdy = ($urandom_range(0, 3) != 0);
      r_rst = ($urandom_range(0, 99) == 0);
      step(r_in, r_rdy, r_rst);
      checks++; if (out_valid !== m_valid) begin errors++; $display("FAIL rand_valid cyc=%0d got %0b want %0b", c, out_valid, m_valid); end
      checks++; if (busy !== model_busy()) begin errors++; $display("FAIL rand_busy cyc=%0d got %0b want %0b", c, busy, model_busy()); end
      checks++; if (merged !== m_merged) begin errors++; $display("FAIL rand_merged cyc=%0d got %0b want %0b", c, merged, m_merged); end
      if (m_valid) begin
        checks++; if (out !== 3'(m_out)) begin errors++; $display("FAIL rand_out cyc=%0d got %0d want %0d", c, out, m_out); end
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    req = 8'h00; out_ready = 1'b0; rst = 1'b1;
    for (int i = 0; i < 8; i++) m_pend[i] = 0;
    m_valid = 0; m_out = 0; m_merged = 0; m_ptr = 7;
    test_reset();
    test_fixed_order();
    test_backpressure();
    test_merge();
    test_arbitration();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
